// File: rtl/pfdispatch.sv
// Prefetch dispatcher: queues prefetch ops, expands each op into two candidate lines,
// and steers surviving candidates to the owning DC pipe. Optional PFDISPATCH_DUPFILT_EN adds a recent-address filter.
module pfdispatch #(
  parameter int LADDR_W   = 40,
  parameter int SPTBR_W   = 38,
  parameter int DELTA_W   = 8,
  parameter int WEIGHT_W  = 4,
  parameter int W_HI      = 8,
  parameter int W_LO      = 4,
  parameter int OPQ_DEPTH = 4,
  parameter int STATBITS  = 16
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                pfgtopfe_op_valid,
  output logic                pfgtopfe_op_retry,
  input  logic [DELTA_W-1:0]  pfgtopfe_op_d1,
  input  logic [DELTA_W-1:0]  pfgtopfe_op_d2,
  input  logic [WEIGHT_W-1:0] pfgtopfe_op_w1,
  input  logic [WEIGHT_W-1:0] pfgtopfe_op_w2,
  input  logic [LADDR_W-1:0]  pfgtopfe_op_laddr,
  input  logic [SPTBR_W-1:0]  pfgtopfe_op_sptbr,

  output logic                pftodc_req0_valid,
  input  logic                pftodc_req0_retry,
  output logic [LADDR_W-1:0]  pftodc_req0_laddr,
  output logic [SPTBR_W-1:0]  pftodc_req0_sptbr,
  output logic                pftodc_req0_l2,

  output logic                pftodc_req1_valid,
  input  logic                pftodc_req1_retry,
  output logic [LADDR_W-1:0]  pftodc_req1_laddr,
  output logic [SPTBR_W-1:0]  pftodc_req1_sptbr,
  output logic                pftodc_req1_l2,

  output logic [STATBITS-1:0] pfd_nissue,
  output logic [STATBITS-1:0] pfd_ndrop
);

  localparam int PTR_W = $clog2(OPQ_DEPTH);
  localparam int CNT_W = $clog2(OPQ_DEPTH + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(OPQ_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [WEIGHT_W-1:0] W_LO_V   = WEIGHT_W'(W_LO);
  localparam logic [WEIGHT_W-1:0] W_HI_V   = WEIGHT_W'(W_HI);

  typedef struct packed {
    logic [DELTA_W-1:0]  d1;
    logic [DELTA_W-1:0]  d2;
    logic [WEIGHT_W-1:0] w1;
    logic [WEIGHT_W-1:0] w2;
    logic [LADDR_W-1:0]  laddr;
    logic [SPTBR_W-1:0]  sptbr;
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_C1, S_C2} state_t;

  // ---------------- op queue ----------------
  op_t              opq_mem [OPQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  op_t              op_in, head;
  logic             push, pop;

  state_t state_reg, state_next;

  assign op_in = '{d1: pfgtopfe_op_d1, d2: pfgtopfe_op_d2,
                   w1: pfgtopfe_op_w1, w2: pfgtopfe_op_w2,
                   laddr: pfgtopfe_op_laddr, sptbr: pfgtopfe_op_sptbr};

  // Retry depends on registered count only: a full queue refuses even when popping.
  assign pfgtopfe_op_retry = (count_reg == CNT_FULL);
  assign push = pfgtopfe_op_valid && !pfgtopfe_op_retry;
  assign head = opq_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) opq_mem[wr_ptr_reg] <= op_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- candidate evaluation ----------------
  logic [DELTA_W-1:0]  cand_d;
  logic [WEIGHT_W-1:0] cand_w;
  logic [LADDR_W-1:0]  cand_addr;
  logic                cand_active, cand_dup, cand_drop, cand_l2, cand_pipe;
  logic [1:0]          pipe_valid, pipe_retry, pipe_free, load;
  logic                resolve, drop_evt;

  assign cand_active = (state_reg != S_IDLE);
  assign cand_d      = (state_reg == S_C2) ? head.d2 : head.d1;
  assign cand_w      = (state_reg == S_C2) ? head.w2 : head.w1;
  assign cand_addr   = head.laddr + {{(LADDR_W-DELTA_W){cand_d[DELTA_W-1]}}, cand_d};
  assign cand_drop   = (cand_d == '0) || (cand_w < W_LO_V) || cand_dup;
  assign cand_l2     = (cand_w < W_HI_V);
  assign cand_pipe   = cand_addr[0];

  assign pipe_retry = {pftodc_req1_retry, pftodc_req0_retry};
  // A register is usable if empty or transferring out this very cycle.
  assign pipe_free  = ~pipe_valid | ~pipe_retry;

  always_comb begin
    load     = 2'b00;
    resolve  = 1'b0;
    drop_evt = 1'b0;
    if (cand_active) begin
      if (cand_drop) begin
        drop_evt = 1'b1;
        resolve  = 1'b1;
      end else if (pipe_free[cand_pipe]) begin
        resolve         = 1'b1;
        load[cand_pipe] = 1'b1;
      end
    end
  end

  assign pop = (state_reg == S_C2) && resolve;

  // ---------------- sequencing FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (count_reg != '0 || push) state_next = S_C1;
      S_C1:   if (resolve) state_next = S_C2;
      S_C2:   if (resolve) state_next = (count_reg > CNT_ONE || push) ? S_C1 : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- per-pipe output registers ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
    logic               valid_reg;
    logic [LADDR_W-1:0] laddr_reg;
    logic [SPTBR_W-1:0] sptbr_reg;
    logic               l2_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg <= 1'b0;
        laddr_reg <= '0;
        sptbr_reg <= '0;
        l2_reg    <= 1'b0;
      end else if (load[gi]) begin
        valid_reg <= 1'b1;
        laddr_reg <= cand_addr;
        sptbr_reg <= head.sptbr;
        l2_reg    <= cand_l2;
      end else if (!pipe_retry[gi]) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign pipe_valid        = {g_pipe[1].valid_reg, g_pipe[0].valid_reg};
  assign pftodc_req0_valid = g_pipe[0].valid_reg;
  assign pftodc_req0_laddr = g_pipe[0].laddr_reg;
  assign pftodc_req0_sptbr = g_pipe[0].sptbr_reg;
  assign pftodc_req0_l2    = g_pipe[0].l2_reg;
  assign pftodc_req1_valid = g_pipe[1].valid_reg;
  assign pftodc_req1_laddr = g_pipe[1].laddr_reg;
  assign pftodc_req1_sptbr = g_pipe[1].sptbr_reg;
  assign pftodc_req1_l2    = g_pipe[1].l2_reg;

  // ---------------- optional duplicate filter ----------------
`ifdef PFDISPATCH_DUPFILT_EN
  logic [LADDR_W-1:0] filt_addr_reg [4];
  logic [3:0]         filt_valid_reg;
  logic [1:0]         filt_ptr_reg;
  logic [3:0]         filt_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_filt
    assign filt_hit[gi] = filt_valid_reg[gi] && (filt_addr_reg[gi] == cand_addr);
  end

  assign cand_dup = |filt_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_valid_reg <= '0;
      filt_ptr_reg   <= '0;
      for (int i = 0; i < 4; i++) filt_addr_reg[i] <= '0;
    end else if (|load) begin
      filt_addr_reg[filt_ptr_reg]  <= cand_addr;
      filt_valid_reg[filt_ptr_reg] <= 1'b1;
      filt_ptr_reg                 <= filt_ptr_reg + 2'd1;
    end
  end
`else
  assign cand_dup = 1'b0;
`endif

  // ---------------- saturating statistics ----------------
  logic [STATBITS-1:0] nissue_reg, ndrop_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      nissue_reg <= '0;
      ndrop_reg  <= '0;
    end else begin
      if (|load && !(&nissue_reg))  nissue_reg <= nissue_reg + STATBITS'(1);
      if (drop_evt && !(&ndrop_reg)) ndrop_reg <= ndrop_reg + STATBITS'(1);
    end
  end

  assign pfd_nissue = nissue_reg;
  assign pfd_ndrop  = ndrop_reg;

endmodule
